// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default bit timing and frame width.
// Used by both the RX and TX sides of the UART library.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BRK   = 3'd4
    } uart_state_e;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 217;
    localparam int unsigned DATA_BITS            = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_8n1_if.sv
// Serial line and received-byte bundle for the 8N1 receiver.
// The receiver uses the master side; the byte consumer/line driver uses the slave side.
interface uart_rx_8n1_if;
    logic       rx;
    logic [7:0] rxbyte;
    logic       rxdone;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx,
        output rxbyte,
        output rxdone,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  rxbyte,
        input  rxdone,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to 1 so an
// idle-high line does not look like an edge coming out of reset.
module uart_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign q = sync2_q;

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: start/8 data LSB-first/stop, one-cycle rxdone or frame_err strobe.
// Define UART_RX_MAJORITY_EN to take each decision sample as a 2-of-3 vote of recent rx_s.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    uart_rx_8n1_if.master     bus
);

    localparam int unsigned HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam logic [15:0] HALF_CNT = 16'(HALF_BIT);
    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    uart_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rxbyte_q, rxbyte_d;
    logic        rxdone_q, rxdone_d;
    logic        frame_err_q, frame_err_d;
    logic        rx_s;
    logic        sample;

    uart_sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx),
        .q   (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // Vote window is the current rx_s plus the two before it, so no latency is added.
    logic [1:0] hist_q, hist_d;

    always_comb begin
        hist_d = {hist_q[0], rx_s};
        sample = maj3(rx_s, hist_q[0], hist_q[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) hist_q <= 2'b11;
        else     hist_q <= hist_d;
    end
`else
    assign sample = rx_s;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rxbyte_d    = rxbyte_q;
        rxdone_d    = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    if (!sample) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    shift_d   = {sample, shift_q[7:1]};
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop lets a start edge right after the stop bit be seen.
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (sample) begin
                        rxbyte_d = shift_q;
                        rxdone_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BRK;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_BRK: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rxbyte_q    <= '0;
            rxdone_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rxbyte_q    <= rxbyte_d;
            rxdone_q    <= rxdone_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.rxbyte    = rxbyte_q;
    assign bus.rxdone    = rxdone_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule
